// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared constants, types and palette for the glyph renderer
package sprite_pkg;

  localparam int GLYPH_W       = 50;
  localparam int GLYPH_H       = 50;
  localparam int NUM_GLYPHS    = 10;
  localparam int IDX_W         = 2;
  localparam int MAX_SHIFT     = 3;
  localparam int KEY_IDX       = 0;
  localparam int COORD_W       = 10;
  localparam int GLYPH_SEL_W   = $clog2(NUM_GLYPHS);
  localparam int SHIFT_W       = $clog2(MAX_SHIFT + 1);
  localparam int ROM_DEPTH     = NUM_GLYPHS * GLYPH_W * GLYPH_H;
  localparam int ADDR_W        = $clog2(ROM_DEPTH);
  localparam int GLYPH_COORD_W = $clog2((GLYPH_W > GLYPH_H) ? GLYPH_W : GLYPH_H);

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef struct packed {
    logic [COORD_W-1:0]     x;
    logic [COORD_W-1:0]     y;
    logic [GLYPH_SEL_W-1:0] glyph;
    logic [SHIFT_W-1:0]     shift;
    logic                   en;
  } cfg_t;

  typedef enum logic {
    CFG_IDLE,
    CFG_PENDING
  } cfg_state_t;

  // Index 0 is the colour key and never reaches the screen, so its entry is black.
  function automatic rgb444_t palette(input logic [IDX_W-1:0] idx);
    rgb444_t c;
    case (idx)
      2'd0:    c = '{4'h0, 4'h0, 4'h0};
      2'd1:    c = '{4'hF, 4'h8, 4'h1};
      2'd2:    c = '{4'h2, 4'hC, 4'h7};
      default: c = '{4'hA, 4'h5, 4'hE};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sprite_glyph_rom.sv
// rtl/sprite_glyph_rom.sv - glyph bank ROM, one-cycle synchronous read
module sprite_glyph_rom
  import sprite_pkg::*;
(
  input  logic              vga_clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [IDX_W-1:0]  idx
);

  logic [IDX_W-1:0] pattern;

  // Artwork is a fixed function of the address bits so the bank needs no load step.
  always_comb begin
    pattern = addr[1:0] + addr[6:5] + addr[12:11];
  end

  // Registered read port, behaves like a block ROM.
  always_ff @(posedge vga_clk) begin
    idx <= pattern;
  end

endmodule

// File: rtl/sprite_glyph_renderer.sv
// rtl/sprite_glyph_renderer.sv - positioned, scaled, colour-keyed glyph overlay
module sprite_glyph_renderer
  import sprite_pkg::*;
(
  input  logic                   vga_clk,
  input  logic                   reset,
  input  logic [COORD_W-1:0]     DrawX,
  input  logic [COORD_W-1:0]     DrawY,
  input  logic                   blank,
  input  logic                   frame_start,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [COORD_W-1:0]     cfg_x,
  input  logic [COORD_W-1:0]     cfg_y,
  input  logic [GLYPH_SEL_W-1:0] cfg_glyph,
  input  logic [SHIFT_W-1:0]     cfg_shift,
  input  logic                   cfg_en,
  output logic [3:0]             red,
  output logic [3:0]             green,
  output logic [3:0]             blue,
  output logic                   hit
);

  localparam logic [ADDR_W-1:0] GLYPH_SIZE = ADDR_W'(GLYPH_W * GLYPH_H);
  localparam logic [ADDR_W-1:0] ROW_SIZE   = ADDR_W'(GLYPH_W);

  cfg_state_t state_q, state_d;
  cfg_t       cfg_in, shadow_q, active_q, cfg_eff;
  logic       cfg_fire, cfg_apply;

  logic [COORD_W:0]         dx, dy, w_lim, h_lim;
  logic                     in_box_c;
  logic [GLYPH_COORD_W-1:0] rx_c, ry_c;

  logic                     in_box_s1, blank_s1;
  logic [GLYPH_COORD_W-1:0] rx_s1, ry_s1;
  logic [GLYPH_SEL_W-1:0]   glyph_s1;
  logic [ADDR_W-1:0]        rom_addr;

  logic                     in_box_s2, blank_s2;
  logic [IDX_W-1:0]         rom_idx;
  logic                     opaque;
  rgb444_t                  pix;

  // Out-of-range glyph/shift requests are clamped as they are captured.
  always_comb begin
    cfg_in.x     = cfg_x;
    cfg_in.y     = cfg_y;
    cfg_in.glyph = (cfg_glyph >= GLYPH_SEL_W'(NUM_GLYPHS)) ? GLYPH_SEL_W'(NUM_GLYPHS - 1) : cfg_glyph;
    cfg_in.shift = ({1'b0, cfg_shift} > (SHIFT_W + 1)'(MAX_SHIFT)) ? SHIFT_W'(MAX_SHIFT) : cfg_shift;
    cfg_in.en    = cfg_en;
  end

  // Handshake: one write is held in the shadow until the next frame boundary.
  always_comb begin
    state_d   = state_q;
    cfg_ready = 1'b0;
    cfg_fire  = 1'b0;
    cfg_apply = 1'b0;
    case (state_q)
      CFG_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          cfg_fire = 1'b1;
          state_d  = CFG_PENDING;
        end
      end
      CFG_PENDING: begin
        if (frame_start) begin
          cfg_apply = 1'b1;
          state_d   = CFG_IDLE;
        end
      end
      default: state_d = CFG_IDLE;
    endcase
  end

  // Handshake state, shadow capture and frame-boundary promotion.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state_q  <= CFG_IDLE;
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      state_q <= state_d;
      if (cfg_fire) shadow_q <= cfg_in;
      if (cfg_apply) active_q <= shadow_q;
    end
  end

  // The frame_start pixel already belongs to the new frame, so it sees the promoted config.
  assign cfg_eff = cfg_apply ? shadow_q : active_q;

  // S1 combinational: box test and glyph-space coordinates; negative dx/dy never wrap.
  always_comb begin
    dx       = {1'b0, DrawX} - {1'b0, cfg_eff.x};
    dy       = {1'b0, DrawY} - {1'b0, cfg_eff.y};
    w_lim    = (COORD_W + 1)'(GLYPH_W) << cfg_eff.shift;
    h_lim    = (COORD_W + 1)'(GLYPH_H) << cfg_eff.shift;
    in_box_c = cfg_eff.en & ~dx[COORD_W] & ~dy[COORD_W] & (dx < w_lim) & (dy < h_lim);
    rx_c     = GLYPH_COORD_W'(dx >> cfg_eff.shift);
    ry_c     = GLYPH_COORD_W'(dy >> cfg_eff.shift);
  end

  // S1 register.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      in_box_s1 <= 1'b0;
      blank_s1  <= 1'b0;
      rx_s1     <= '0;
      ry_s1     <= '0;
      glyph_s1  <= '0;
    end else begin
      in_box_s1 <= in_box_c;
      blank_s1  <= blank;
      rx_s1     <= rx_c;
      ry_s1     <= ry_c;
      glyph_s1  <= cfg_eff.glyph;
    end
  end

  // S2 address: constant multipliers only, parked at 0 outside the box.
  always_comb begin
    rom_addr = '0;
    if (in_box_s1) begin
      rom_addr = ADDR_W'(glyph_s1) * GLYPH_SIZE + ADDR_W'(ry_s1) * ROW_SIZE + ADDR_W'(rx_s1);
    end
  end

  sprite_glyph_rom u_rom (
    .vga_clk (vga_clk),
    .addr    (rom_addr),
    .idx     (rom_idx)
  );

  // S2 register: qualifiers ride alongside the ROM read.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      in_box_s2 <= 1'b0;
      blank_s2  <= 1'b0;
    end else begin
      in_box_s2 <= in_box_s1;
      blank_s2  <= blank_s1;
    end
  end

  // S3 palette lookup and colour-key test.
  always_comb begin
    pix    = palette(rom_idx);
    opaque = in_box_s2 & (rom_idx != IDX_W'(KEY_IDX));
  end

  // Output register: black unless an opaque sprite pixel lands in active video.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
      hit   <= 1'b0;
    end else if (blank_s2 & opaque) begin
      red   <= pix.r;
      green <= pix.g;
      blue  <= pix.b;
      hit   <= 1'b1;
    end else begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
      hit   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sprite_glyph_renderer.sv
// tb/tb_sprite_glyph_renderer.sv - self-checking bench for sprite_glyph_renderer
module tb_sprite_glyph_renderer;

  logic       vga_clk = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] DrawX = '0, DrawY = '0;
  logic       blank = 1'b0, frame_start = 1'b0, cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [9:0] cfg_x = '0, cfg_y = '0;
  logic [3:0] cfg_glyph = '0;
  logic [1:0] cfg_shift = '0;
  logic       cfg_en = 1'b0;
  logic [3:0] red, green, blue;
  logic       hit;

  int total = 0;
  int bad = 0;

  // reference model state
  int a_x, a_y, a_g, a_s, a_en;
  int s_x, s_y, s_g, s_s, s_en;
  bit m_pend;
  int c_x, c_y, c_g, c_s, c_en;
  logic [12:0] exp_q[$];

  sprite_glyph_renderer dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank       (blank),
    .frame_start (frame_start),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_x       (cfg_x),
    .cfg_y       (cfg_y),
    .cfg_glyph   (cfg_glyph),
    .cfg_shift   (cfg_shift),
    .cfg_en      (cfg_en),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .hit         (hit)
  );

  always #5 vga_clk = ~vga_clk;

  function automatic int art(input int a);
    return ((a % 4) + ((a / 32) % 4) + ((a / 2048) % 4)) % 4;
  endfunction

  function automatic logic [11:0] colour(input int i);
    if (i == 1) return 12'hF81;
    if (i == 2) return 12'h2C7;
    return 12'hA5E;
  endfunction

  // {r,g,b,hit} expected for one pixel under the given config
  function automatic logic [12:0] ref_px(input int px, input int py, input bit b,
                                         input int cx, input int cy, input int cg,
                                         input int cs, input int cen);
    int sc, dx, dy, ad, i;
    sc = 1 << cs;
    dx = px - cx;
    dy = py - cy;
    if (cen == 0 || dx < 0 || dy < 0 || dx >= 50 * sc || dy >= 50 * sc) return 13'h0;
    ad = cg * 2500 + (dy / sc) * 50 + (dx / sc);
    i = art(ad);
    if (i == 0 || !b) return 13'h0;
    return {colour(i), 1'b1};
  endfunction

  task automatic model_reset();
    a_x = 0; a_y = 0; a_g = 0; a_s = 0; a_en = 0;
    s_x = 0; s_y = 0; s_g = 0; s_s = 0; s_en = 0;
    m_pend = 0;
    exp_q.delete();
    repeat (3) exp_q.push_back(13'h0);
  endtask

  task automatic step(input int px, input int py, input bit b, input bit fs, input bit cv);
    logic [12:0] e;
    bit was_pend;
    @(posedge vga_clk);
    #1;
    e = exp_q.pop_front();
    total++;
    assert ({red, green, blue, hit} === e)
      else begin bad++; $error("FAIL pixel obs=%h exp=%h", {red, green, blue, hit}, e); end
    total++;
    assert (cfg_ready === !m_pend)
      else begin bad++; $error("FAIL cfg_ready obs=%b exp=%b", cfg_ready, !m_pend); end
    DrawX = 10'(px); DrawY = 10'(py); blank = b; frame_start = fs; cfg_valid = cv;
    cfg_x = 10'(c_x); cfg_y = 10'(c_y); cfg_glyph = 4'(c_g); cfg_shift = 2'(c_s); cfg_en = c_en[0];
    was_pend = m_pend;
    if (fs && was_pend) begin
      a_x = s_x; a_y = s_y; a_g = s_g; a_s = s_s; a_en = s_en;
      m_pend = 0;
    end
    exp_q.push_back(ref_px(px, py, b, a_x, a_y, a_g, a_s, a_en));
    if (cv && !was_pend) begin
      s_x = c_x; s_y = c_y; s_g = (c_g >= 10) ? 9 : c_g; s_s = (c_s > 3) ? 3 : c_s; s_en = c_en;
      m_pend = 1;
    end
  endtask

  task automatic do_reset();
    cfg_valid = 0; frame_start = 0;
    reset = 1;
    #1;
    total++;
    assert ({red, green, blue} === 12'h0)
      else begin bad++; $error("FAIL rst_rgb obs=%h exp=000", {red, green, blue}); end
    total++;
    assert (hit === 1'b0) else begin bad++; $error("FAIL rst_hit obs=%b exp=0", hit); end
    total++;
    assert (cfg_ready === 1'b1) else begin bad++; $error("FAIL rst_ready obs=%b exp=1", cfg_ready); end
    repeat (2) @(posedge vga_clk);
    #1;
    reset = 0;
    model_reset();
  endtask

  task automatic set_cfg(input int x, input int y, input int g, input int s, input int en);
    c_x = x; c_y = y; c_g = g; c_s = s; c_en = en;
  endtask

  initial begin
    set_cfg(0, 0, 0, 0, 0);
    #2;
    do_reset();

    // first config: not visible until the next frame_start
    set_cfg(100, 80, 1, 0, 1);
    step(0, 0, 1, 0, 1);
    repeat (3) step(100, 80, 1, 0, 0);
    step(0, 0, 1, 1, 0);
    for (int x = 95; x <= 155; x++) step(x, 80, 1, 0, 0);
    step(100, 80, 0, 0, 0);
    repeat (150) step($urandom_range(90, 160), $urandom_range(70, 140), ($urandom % 8) != 0, 0, 0);

    // scale x4
    set_cfg(100, 80, 1, 2, 1);
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 1, 0);
    for (int x = 96; x <= 305; x++) step(x, 80, 1, 0, 0);
    repeat (150) step($urandom_range(90, 310), $urandom_range(70, 290), ($urandom % 8) != 0, 0, 0);

    // write coincident with frame_start: old config this frame, new one next frame
    set_cfg(300, 200, 5, 1, 1);
    step(0, 0, 1, 1, 1);
    repeat (60) step($urandom_range(90, 420), $urandom_range(70, 320), 1, 0, 0);
    step(0, 0, 1, 1, 0);
    repeat (60) step($urandom_range(90, 420), $urandom_range(70, 320), 1, 0, 0);

    // right-edge clipping and glyph clamp
    set_cfg(620, 10, 12, 0, 1);
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 1, 0);
    for (int y = 10; y <= 11; y++) begin
      for (int x = 610; x <= 639; x++) step(x, y, 1, 0, 0);
      for (int x = 0; x <= 30; x++) step(x, y, 1, 0, 0);
    end

    // random configs, writes and frame boundaries interleaved with pixels
    repeat (8) begin
      set_cfg($urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 15),
              $urandom_range(0, 3), ($urandom % 10) != 0);
      step(0, 0, 1, $urandom % 2, 1);
      step(0, 0, 1, 1, 0);
      repeat (80) begin
        if ($urandom % 20 == 0)
          set_cfg($urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 15),
                  $urandom_range(0, 3), 1);
        step((c_x + 630 + $urandom_range(0, 420)) % 640, (c_y + 470 + $urandom_range(0, 420)) % 480,
             ($urandom % 8) != 0, ($urandom % 30) == 0, ($urandom % 20) == 0);
      end
    end

    // reset in the middle of a drawn glyph
    set_cfg(100, 80, 3, 0, 1);
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 1, 0);
    for (int x = 100; x <= 112; x++) step(x, 81, 1, 0, 0);
    do_reset();
    for (int x = 100; x <= 110; x++) step(x, 81, 1, 0, 0);
    step(0, 0, 1, 1, 0);
    for (int x = 100; x <= 110; x++) step(x, 81, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
